time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Time-setting controller for the digital clock.
- Sequences the h/m/s counter chain through RUN and field-by-field SET modes.
- Edits a shadow copy of the time from mode/inc/dec buttons, with auto-repeat on held buttons and a timeout.
- Issues a one-cycle parallel load to the counters on commit, drives the display source mux and produces per-field blink masks for the 7-segment decoders.

Parameters:
REPEAT_DLY, 5, ticks a held inc/dec must persist before auto-repeat starts
REPEAT_RATE, 2, ticks between auto-repeat steps once repeating
TIMEOUT, 100, ticks without any button press in a SET state before abort to RUN
BLINK_TICKS, 3, ticks per blink half-period

Ports:
clk  input  1  system clock; all logic is in this domain
rst  input  1  synchronous, active-high reset, sampled on rising clk
tick  input  1  single-cycle timing strobe (nominal 10 Hz) from the clock divider
btn_mode  input  1  debounced, synchronised level, 1 = pressed
btn_inc  input  1  debounced, synchronised level
btn_dec  input  1  debounced, synchronised level
cur_h  input  7  live hour counter value, 0..23
cur_m  input  7  live minute counter value, 0..59
cur_s  input  7  live second counter value, 0..59
cnt_en  output  1  counter run gate; 1 = counters advance
load  output  1  one-cycle pulse; counters load set_h/set_m/set_s
set_h  output  7  shadow hour value
set_m  output  7  shadow minute value
set_s  output  7  shadow second value
disp_h  output  7  hour value to display
disp_m  output  7  minute value to display
disp_s  output  7  second value to display
blink_mask  output  3  blank request for display fields [2]=h, [1]=m, [0]=s; 1 = blank
mode_o  output  2  current state: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S

Behaviour:
- All outputs are registered.
- Reset: state RUN, cnt_en=1, load=0, set_*=0, blink_mask=0, all tick counters=0, button edge registers=0.
- Reset asserted mid-SET discards the shadow values without issuing a load.
- Press = rising edge of a button level (registered previous value). Held levels produce no further presses.
- FSM transitions:
  - RUN + mode press -> SET_H. Same cycle: set_h/m/s <= cur_h/m/s; cnt_en <= 0.
  - SET_H + mode press -> SET_M.
  - SET_M + mode press -> SET_S.
  - SET_S + mode press -> RUN. Same cycle: load <= 1 for exactly one cycle; cnt_en <= 1. set_* remain stable during and after the load pulse.
  - Any SET state with TIMEOUT consecutive ticks and no press on any button -> RUN. No load is issued; cnt_en <= 1.
- Timeout counter clears on every press, including inc/dec presses and auto-repeat steps.
- Edit rules, applied to the active field only:
  - inc: value+1, wrapping at limit. Limit is 24 for h, 60 for m and s (23+1 -> 0; 59+1 -> 0).
  - dec: value-1, wrapping 0 -> limit-1.
  - Arithmetic is 7-bit; shadow registers never hold an out-of-range value.
- Priority within one cycle:
  - Mode press beats inc/dec: the mode transition happens and no edit is made.
  - inc and dec both high: no edit, and the repeat counter is held at 0.
- Auto-repeat:
  - Exactly one of inc/dec held after its press: a repeat counter counts ticks.
  - When it reaches REPEAT_DLY: one step, counter reloads to 0.
  - Thereafter: one step every REPEAT_RATE ticks.
  - Release of the button, or a state change, clears the counter and the repeat phase.
- Blink:
  - A phase bit toggles every BLINK_TICKS ticks. It is forced to 0 (visible) on entry to each SET state and on every edit step.
  - blink_mask = phase on the active field bit only.
  - blink_mask = 000 in RUN.
- Display mux: RUN -> disp_* = cur_*. SET states -> disp_* = set_*. The output updates the cycle after the state changes.
- Ticks are ignored in RUN except by the blink counter, which is held at 0 in RUN.

Test Plan:
1. Reset, then hold cur=12:34:56 and press mode -> mode_o=1, cnt_en=0, set=12:34:56, disp=12:34:56, blink_mask toggles 100/000 every 3 ticks.
2. In SET_H with set_h=23, press inc -> set_h=0. Press dec -> 23. Press inc and dec in the same cycle -> no change.
3. In SET_M with set_m=58, hold inc -> step to 59 at press; 0 after 5 ticks; then 1, 2 at 2-tick intervals. Release -> no further change.
4. Full sequence: mode x3 with edits to 07:15:00, then mode -> load high exactly 1 cycle, set=07:15:00, mode_o=0, cnt_en=1.
5. In SET_S, wait 100 ticks with no press -> mode_o=0, cnt_en=1, load never asserted. Separately, a press at tick 99 restarts the count.
6. Mode press and inc press in the same cycle in SET_H -> mode_o=2, set_h unchanged. Separately, rst asserted in SET_M -> next cycle mode_o=0, set_*=0, load=0.

Source files
------------

// File: rtl/time_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : time_set_ctrl                                                |
// | Description : Time-setting controller for the digital clock. Runs the      |
// |               h/m/s chain, edits a shadow time field by field with         |
// |               auto-repeat and timeout, commits with a one-cycle load,      |
// |               and drives the display mux and per-field blink masks.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module time_set_ctrl #(
  parameter int REPEAT_DLY  = 5,
  parameter int REPEAT_RATE = 2,
  parameter int TIMEOUT     = 100,
  parameter int BLINK_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [6:0] cur_h,
  input  logic [6:0] cur_m,
  input  logic [6:0] cur_s,
  output logic       cnt_en,
  output logic       load,
  output logic [6:0] set_h,
  output logic [6:0] set_m,
  output logic [6:0] set_s,
  output logic [6:0] disp_h,
  output logic [6:0] disp_m,
  output logic [6:0] disp_s,
  output logic [2:0] blink_mask,
  output logic [1:0] mode_o
);

  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int BW      = $clog2(BLINK_TICKS + 1);
  localparam logic [6:0] LIM_H  = 7'd24;
  localparam logic [6:0] LIM_MS = 7'd60;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      set_h_q, set_h_d, set_m_q, set_m_d, set_s_q, set_s_d;
  logic [6:0]      disp_h_q, disp_h_d, disp_m_q, disp_m_d, disp_s_q, disp_s_d;
  logic            cnt_en_q, cnt_en_d, load_q, load_d;
  logic [2:0]      blink_mask_q, blink_mask_d;
  logic            mode_prev_q, inc_prev_q, dec_prev_q;
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
  logic            rep_phase_q, rep_phase_d;
  logic            rep_arm_q, rep_arm_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            mode_p, inc_p, dec_p;
  logic            do_step, step_up;

  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] lim);
    return (v >= lim - 7'd1) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] wrap_dec(input logic [6:0] v, input logic [6:0] lim);
    return (v == 7'd0 || v >= lim) ? lim - 7'd1 : v - 7'd1;
  endfunction

  // Live values that are out of range must never reach the shadow registers
  function automatic logic [6:0] clamp(input logic [6:0] v, input logic [6:0] lim);
    return (v >= lim) ? 7'd0 : v;
  endfunction

  // Next-state logic: mode sequencing, editing, auto-repeat, timeout and blink
  always_comb begin
    mode_p        = btn_mode & ~mode_prev_q;
    inc_p         = btn_inc & ~inc_prev_q;
    dec_p         = btn_dec & ~dec_prev_q;
    state_d       = state_q;
    set_h_d       = set_h_q;
    set_m_d       = set_m_q;
    set_s_d       = set_s_q;
    load_d        = 1'b0;
    rep_cnt_d     = rep_cnt_q;
    rep_phase_d   = rep_phase_q;
    rep_arm_d     = rep_arm_q;
    to_cnt_d      = to_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    do_step       = 1'b0;
    step_up       = 1'b0;

    if (state_q == ST_RUN) begin
      rep_cnt_d     = '0;
      rep_phase_d   = 1'b0;
      rep_arm_d     = 1'b0;
      to_cnt_d      = '0;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
      if (mode_p) begin
        state_d = ST_SET_H;
        set_h_d = clamp(cur_h, LIM_H);
        set_m_d = clamp(cur_m, LIM_MS);
        set_s_d = clamp(cur_s, LIM_MS);
      end
    end else if (mode_p) begin
      // Mode wins over any inc/dec activity in the same cycle
      rep_cnt_d     = '0;
      rep_phase_d   = 1'b0;
      rep_arm_d     = 1'b0;
      to_cnt_d      = '0;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
      case (state_q)
        ST_SET_H: state_d = ST_SET_M;
        ST_SET_M: state_d = ST_SET_S;
        default: begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end
      endcase
    end else begin
      // Conflicting buttons cancel each other and disarm repeat
      if (btn_inc && btn_dec) begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_arm_d   = 1'b0;
      end else if (inc_p || dec_p) begin
        do_step     = 1'b1;
        step_up     = inc_p;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_arm_d   = 1'b1;
      end else if ((btn_inc || btn_dec) && rep_arm_q) begin
        if (tick) begin
          if ((!rep_phase_q && rep_cnt_q == RW'(REPEAT_DLY - 1)) ||
              ( rep_phase_q && rep_cnt_q == RW'(REPEAT_RATE - 1))) begin
            do_step     = 1'b1;
            step_up     = btn_inc;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
          end
        end
      end else begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_arm_d   = 1'b0;
      end

      if (do_step) begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        case (state_q)
          ST_SET_H: set_h_d = step_up ? wrap_inc(set_h_q, LIM_H)  : wrap_dec(set_h_q, LIM_H);
          ST_SET_M: set_m_d = step_up ? wrap_inc(set_m_q, LIM_MS) : wrap_dec(set_m_q, LIM_MS);
          default:  set_s_d = step_up ? wrap_inc(set_s_q, LIM_MS) : wrap_dec(set_s_q, LIM_MS);
        endcase
      end else if (tick) begin
        if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end

      // Any press, including a simultaneous inc+dec, restarts the idle count
      if (inc_p || dec_p || do_step) begin
        to_cnt_d = '0;
      end else if (tick) begin
        if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d       = ST_RUN;
          to_cnt_d      = '0;
          rep_cnt_d     = '0;
          rep_phase_d   = 1'b0;
          rep_arm_d     = 1'b0;
          blink_cnt_d   = '0;
          blink_phase_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
    end

    cnt_en_d = (state_d == ST_RUN);
    case (state_d)
      ST_SET_H: blink_mask_d = {blink_phase_d, 2'b00};
      ST_SET_M: blink_mask_d = {1'b0, blink_phase_d, 1'b0};
      ST_SET_S: blink_mask_d = {2'b00, blink_phase_d};
      default:  blink_mask_d = 3'b000;
    endcase

    // Display follows the state that was current before this edge
    if (state_q == ST_RUN) begin
      disp_h_d = cur_h;
      disp_m_d = cur_m;
      disp_s_d = cur_s;
    end else begin
      disp_h_d = set_h_q;
      disp_m_d = set_m_q;
      disp_s_d = set_s_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      set_h_q       <= '0;
      set_m_q       <= '0;
      set_s_q       <= '0;
      disp_h_q      <= '0;
      disp_m_q      <= '0;
      disp_s_q      <= '0;
      cnt_en_q      <= 1'b1;
      load_q        <= 1'b0;
      blink_mask_q  <= '0;
      mode_prev_q   <= 1'b0;
      inc_prev_q    <= 1'b0;
      dec_prev_q    <= 1'b0;
      rep_cnt_q     <= '0;
      rep_phase_q   <= 1'b0;
      rep_arm_q     <= 1'b0;
      to_cnt_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      set_h_q       <= set_h_d;
      set_m_q       <= set_m_d;
      set_s_q       <= set_s_d;
      disp_h_q      <= disp_h_d;
      disp_m_q      <= disp_m_d;
      disp_s_q      <= disp_s_d;
      cnt_en_q      <= cnt_en_d;
      load_q        <= load_d;
      blink_mask_q  <= blink_mask_d;
      mode_prev_q   <= btn_mode;
      inc_prev_q    <= btn_inc;
      dec_prev_q    <= btn_dec;
      rep_cnt_q     <= rep_cnt_d;
      rep_phase_q   <= rep_phase_d;
      rep_arm_q     <= rep_arm_d;
      to_cnt_q      <= to_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign mode_o     = state_q;
  assign cnt_en     = cnt_en_q;
  assign load       = load_q;
  assign set_h      = set_h_q;
  assign set_m      = set_m_q;
  assign set_s      = set_s_q;
  assign disp_h     = disp_h_q;
  assign disp_m     = disp_m_q;
  assign disp_s     = disp_s_q;
  assign blink_mask = blink_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_time_set_ctrl                                             |
// | Description : Self-checking bench for time_set_ctrl with an expected-value |
// |               queue filled at stimulus time and drained at compare time.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [6:0] cur_h = 7'd0;
  logic [6:0] cur_m = 7'd0;
  logic [6:0] cur_s = 7'd0;
  logic       cnt_en, load;
  logic [6:0] set_h, set_m, set_s, disp_h, disp_m, disp_s;
  logic [2:0] blink_mask;
  logic [1:0] mode_o;

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  logic [27:0] exp_q[$];
  logic [27:0] e, obs;

  time_set_ctrl #(
    .REPEAT_DLY(5), .REPEAT_RATE(2), .TIMEOUT(100), .BLINK_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .cnt_en(cnt_en), .load(load),
    .set_h(set_h), .set_m(set_m), .set_s(set_s),
    .disp_h(disp_h), .disp_m(disp_m), .disp_s(disp_s),
    .blink_mask(blink_mask), .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  // Counts every load pulse the design ever issues
  always @(posedge clk) if (!rst && load) load_cnt <= load_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [27:0] pack(input logic [1:0] m, input logic ce, input logic ld,
                                       input logic [2:0] bm, input logic [6:0] h,
                                       input logic [6:0] mi, input logic [6:0] s);
    return {m, ce, ld, bm, h, mi, s};
  endfunction

  function automatic logic [27:0] snap();
    return {mode_o, cnt_en, load, blink_mask, set_h, set_m, set_s};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
  endtask

  // which: 0 = mode, 1 = inc, 2 = dec
  task automatic press(input int which);
    if (which == 0) btn_mode = 1'b1; else if (which == 1) btn_inc = 1'b1; else btn_dec = 1'b1;
    cyc(1);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
  endtask

  task automatic test_reset();
    cur_h = 7'd12; cur_m = 7'd34; cur_s = 7'd56;
    rst = 1'b1;
    exp_q.push_back(pack(2'd0, 1'b1, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0));
    cyc(2);
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_state: got %h want %h", obs, e); end
    rst = 1'b0;
    exp_q.push_back({7'd0, 7'd12, 7'd34, 7'd56});
    cyc(1);
    obs = {7'd0, disp_h, disp_m, disp_s}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL run_disp: got %h want %h", obs, e); end
  endtask

  task automatic test_enter_set();
    btn_mode = 1'b1;
    exp_q.push_back(pack(2'd1, 1'b0, 1'b0, 3'b000, 7'd12, 7'd34, 7'd56));
    cyc(1);
    btn_mode = 1'b0;
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL enter_set_h: got %h want %h", obs, e); end
    exp_q.push_back({7'd0, 7'd12, 7'd34, 7'd56});
    cyc(1);
    obs = {7'd0, disp_h, disp_m, disp_s}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL set_disp: got %h want %h", obs, e); end
    pulse_tick(); pulse_tick();
    exp_q.push_back({25'd0, 3'b000});
    obs = {25'd0, blink_mask}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL blink_before_3: got %h want %h", obs, e); end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({25'd0, (k % 2 == 0) ? 3'b100 : 3'b000});
      if (k == 0) pulse_tick(); else repeat (3) pulse_tick();
      obs = {25'd0, blink_mask}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL blink_phase_%0d: got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_wrap_h();
    logic [6:0] h;
    h = 7'd12;
    for (int i = 0; i < 13; i++) begin
      h = (h == 7'd0) ? 7'd23 : h - 7'd1;
      exp_q.push_back(pack(2'd1, 1'b0, 1'b0, 3'b000, h, 7'd34, 7'd56));
      press(2);
      e = exp_q.pop_front();
      if (i >= 11) begin
        obs = snap(); total++;
        if (obs !== e) begin bad++; $display("FAIL dec_h_%0d: got %h want %h", i, obs, e); end
      end
    end
    exp_q.push_back(pack(2'd1, 1'b0, 1'b0, 3'b000, 7'd0, 7'd34, 7'd56));
    press(1);
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL inc_wrap_h: got %h want %h", obs, e); end
    exp_q.push_back(pack(2'd1, 1'b0, 1'b0, 3'b000, 7'd23, 7'd34, 7'd56));
    press(2);
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL dec_wrap_h: got %h want %h", obs, e); end
    btn_inc = 1'b1; btn_dec = 1'b1;
    exp_q.push_back(pack(2'd1, 1'b0, 1'b0, 3'b000, 7'd23, 7'd34, 7'd56));
    cyc(1);
    btn_inc = 1'b0; btn_dec = 1'b0;
    cyc(1);
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL inc_dec_same: got %h want %h", obs, e); end
  endtask

  task automatic test_repeat();
    logic [6:0] hold_exp [9];
    hold_exp = '{7'd59, 7'd59, 7'd59, 7'd59, 7'd0, 7'd0, 7'd1, 7'd1, 7'd2};
    exp_q.push_back(pack(2'd2, 1'b0, 1'b0, 3'b000, 7'd23, 7'd34, 7'd56));
    press(0);
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL enter_set_m: got %h want %h", obs, e); end
    repeat (24) press(1);
    exp_q.push_back({21'd0, 7'd58});
    obs = {21'd0, set_m}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL set_m_58: got %h want %h", obs, e); end
    btn_inc = 1'b1;
    exp_q.push_back({21'd0, 7'd59});
    cyc(1);
    obs = {21'd0, set_m}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL hold_press: got %h want %h", obs, e); end
    for (int t = 0; t < 9; t++) begin
      exp_q.push_back({21'd0, hold_exp[t]});
      pulse_tick();
      obs = {21'd0, set_m}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL repeat_tick_%0d: got %h want %h", t + 1, obs, e); end
    end
    btn_inc = 1'b0;
    exp_q.push_back({21'd0, 7'd2});
    repeat (6) pulse_tick();
    obs = {21'd0, set_m}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL after_release: got %h want %h", obs, e); end
  endtask

  task automatic test_full_commit();
    int ld0;
    cur_h = 7'd5; cur_m = 7'd13; cur_s = 7'd58;
    do_reset();
    cyc(1);
    press(0); press(1); press(1);
    press(0); press(1); press(1);
    press(0); press(1); press(1);
    exp_q.push_back(pack(2'd3, 1'b0, 1'b0, 3'b000, 7'd7, 7'd15, 7'd0));
    exp_q.push_back({7'd0, 7'd7, 7'd15, 7'd0});
    cyc(1);
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL before_commit: got %h want %h", obs, e); end
    obs = {7'd0, disp_h, disp_m, disp_s}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL set_s_disp: got %h want %h", obs, e); end
    ld0 = load_cnt;
    btn_mode = 1'b1;
    exp_q.push_back(pack(2'd0, 1'b1, 1'b1, 3'b000, 7'd7, 7'd15, 7'd0));
    exp_q.push_back(pack(2'd0, 1'b1, 1'b0, 3'b000, 7'd7, 7'd15, 7'd0));
    cyc(1);
    btn_mode = 1'b0;
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL commit_cycle: got %h want %h", obs, e); end
    cyc(1);
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL after_commit: got %h want %h", obs, e); end
    exp_q.push_back({7'd0, 7'd5, 7'd13, 7'd58});
    exp_q.push_back(28'd1);
    cyc(3);
    obs = {7'd0, disp_h, disp_m, disp_s}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL run_disp_back: got %h want %h", obs, e); end
    obs = 28'(load_cnt - ld0); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL load_pulses: got %0d want %0d", obs, e); end
  endtask

  task automatic test_timeout();
    int ld0;
    do_reset();
    cyc(1);
    press(0); press(0); press(0);
    ld0 = load_cnt;
    exp_q.push_back({26'd0, 2'd3});
    repeat (99) pulse_tick();
    obs = {26'd0, mode_o}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL no_timeout_99: got %h want %h", obs, e); end
    press(1);
    exp_q.push_back({25'd0, 2'd3, 1'b0});
    repeat (99) pulse_tick();
    obs = {25'd0, mode_o, cnt_en}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL restart_count: got %h want %h", obs, e); end
    exp_q.push_back({25'd0, 2'd0, 1'b1});
    pulse_tick();
    obs = {25'd0, mode_o, cnt_en}; e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL timeout_run: got %h want %h", obs, e); end
    exp_q.push_back(28'd0);
    cyc(3);
    obs = 28'(load_cnt - ld0); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL timeout_load: got %0d want %0d", obs, e); end
  endtask

  task automatic test_priority_and_reset();
    int ld0;
    do_reset();
    cyc(1);
    press(0);
    btn_mode = 1'b1; btn_inc = 1'b1;
    exp_q.push_back(pack(2'd2, 1'b0, 1'b0, 3'b000, 7'd5, 7'd13, 7'd58));
    cyc(1);
    btn_mode = 1'b0; btn_inc = 1'b0;
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL mode_beats_inc: got %h want %h", obs, e); end
    cyc(2);
    ld0 = load_cnt;
    rst = 1'b1;
    exp_q.push_back(pack(2'd0, 1'b1, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0));
    cyc(1);
    rst = 1'b0;
    obs = snap(); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_mid_set: got %h want %h", obs, e); end
    exp_q.push_back(28'd0);
    cyc(3);
    obs = 28'(load_cnt - ld0); e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_load: got %0d want %0d", obs, e); end
  endtask

  initial begin
    cyc(1);
    test_reset();
    test_enter_set();
    test_wrap_h();
    test_repeat();
    test_full_commit();
    test_timeout();
    test_priority_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
